// File: rtl/s2_receiver.sv
// S2 serial receiver: 13-bit frames (5-bit addr, 8-bit data, MSB first) on sen/sd become register-bank-2 writes.
// One-cycle write strobe the cycle after the last bit; no backpressure, and S2_done latches after 18 accepted words.
module s2_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       updown,
    inout  wire        sen,
    inout  wire        sd,
    output logic       RB2_RW,
    output logic [4:0] RB2_A,
    output logic [7:0] RB2_D,
    input  logic [7:0] RB2_Q,
    output logic       S2_done
);
    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

    localparam logic [4:0] NUM_WORDS = 5'd18;
    localparam logic [4:0] MAX_ADDR  = 5'd17;
    localparam logic [3:0] LAST_BIT  = 4'd12;

    state_t      state_q;
    logic [3:0]  bitcnt_q;
    logic [12:0] shreg_q;
    logic [4:0]  wcnt_q;
    logic        rw_q;
    logic [4:0]  a_q;
    logic [7:0]  d_q;
    logic        done_q;

    logic [12:0] shreg_d;
    logic        addr_ok_d;
    logic        frame_go;
    logic        unused_rb2_q;

    // This block only listens on the serial pins.
    assign sen = 1'bz;
    assign sd  = 1'bz;

    assign unused_rb2_q = ^RB2_Q;

    assign frame_go  = !sen && !updown;
    assign shreg_d   = {shreg_q[11:0], sd};
    assign addr_ok_d = (shreg_d[12:8] <= MAX_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= 4'd0;
            shreg_q  <= 13'd0;
            wcnt_q   <= 5'd0;
            rw_q     <= 1'b1;
            a_q      <= 5'd0;
            d_q      <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            // Write strobe is low for exactly the one WRITE cycle.
            rw_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (frame_go) begin
                        shreg_q  <= {12'd0, sd};
                        bitcnt_q <= 4'd1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (updown || sen) begin
                        shreg_q  <= 13'd0;
                        bitcnt_q <= 4'd0;
                        state_q  <= IDLE;
                    end else if (bitcnt_q == LAST_BIT) begin
                        shreg_q  <= shreg_d;
                        bitcnt_q <= 4'd0;
                        state_q  <= WRITE;
                        if (addr_ok_d) begin
                            rw_q   <= 1'b0;
                            a_q    <= shreg_d[12:8];
                            d_q    <= shreg_d[7:0];
                            wcnt_q <= wcnt_q + 5'd1;
                        end
                    end else begin
                        shreg_q  <= shreg_d;
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end
                end
                WRITE: begin
                    if (wcnt_q == NUM_WORDS) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (frame_go) begin
                        // Zero-gap frames: this cycle already carries bit 0 of the next one.
                        shreg_q  <= {12'd0, sd};
                        bitcnt_q <= 4'd1;
                        state_q  <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    assign RB2_RW  = rw_q;
    assign RB2_A   = a_q;
    assign RB2_D   = d_q;
    assign S2_done = done_q;
endmodule

// File: tb/tb_s2_receiver.sv
// Scoreboard bench for s2_receiver: stimulus queues expected {addr,data} writes, a monitor pops on every write strobe.
module tb_s2_receiver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       updown;
    logic       sen_drv;
    logic       sd_drv;
    wire        sen;
    wire        sd;
    logic       RB2_RW;
    logic [4:0] RB2_A;
    logic [7:0] RB2_D;
    logic [7:0] RB2_Q;
    logic       S2_done;

    assign sen = sen_drv;
    assign sd  = sd_drv;

    s2_receiver dut (
        .clk     (clk),
        .rst     (rst),
        .updown  (updown),
        .sen     (sen),
        .sd      (sd),
        .RB2_RW  (RB2_RW),
        .RB2_A   (RB2_A),
        .RB2_D   (RB2_D),
        .RB2_Q   (RB2_Q),
        .S2_done (S2_done)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d);
        @(negedge clk);
        sen_drv = s;
        sd_drv  = d;
    endtask

    task automatic send_bits(input logic [12:0] f, input int n);
        for (int i = 12; i > 12 - n; i--) drive(1'b0, f[i]);
    endtask

    task automatic send_frame(input logic [4:0] a, input logic [7:0] d, input bit expect_wr);
        if (expect_wr) exp_q.push_back({a, d});
        send_bits({a, d}, 13);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic sample;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (RB2_RW !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h rw=%b expected no write",
                             RB2_A, RB2_D, RB2_RW);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("write_pair", {19'd0, RB2_A, RB2_D}, {19'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] f;
        logic [7:0]  dd;

        rst     = 1'b1;
        updown  = 1'b0;
        sen_drv = 1'b1;
        sd_drv  = 1'b0;
        RB2_Q   = 8'd0;

        repeat (2) sample();
        check("reset_rw", RB2_RW, 1);
        check("reset_a", RB2_A, 0);
        check("reset_d", RB2_D, 0);
        check("reset_done", S2_done, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single frame: write visible one cycle after the last bit.
        send_frame(5'd3, 8'hA5, 1'b1);
        sample();
        check("lat_rw", RB2_RW, 0);
        check("lat_a", RB2_A, 3);
        check("lat_d", RB2_D, 8'hA5);
        idle(1);
        sample();
        check("rw_after_write", RB2_RW, 1);
        check("a_hold", RB2_A, 3);

        // Short frame discarded, then a full frame.
        send_bits({5'd9, 8'h33}, 7);
        idle(2);
        send_frame(5'd1, 8'h0F, 1'b1);
        idle(2);
        check("short_then_full_a", RB2_A, 1);
        check("short_then_full_d", RB2_D, 8'h0F);

        // updown raised at bit 6 aborts the frame.
        f = {5'd4, 8'h44};
        send_bits(f, 6);
        @(negedge clk);
        updown  = 1'b1;
        sen_drv = 1'b0;
        sd_drv  = f[6];
        for (int i = 5; i >= 0; i--) drive(1'b0, f[i]);
        idle(1);
        updown = 1'b0;
        idle(2);
        check("updown_no_write_a", RB2_A, 1);
        send_frame(5'd4, 8'h44, 1'b1);
        idle(2);
        check("updown_recover_a", RB2_A, 4);

        // Reset at bit 10 suppresses the write and clears the outputs.
        f = {5'd7, 8'hC3};
        send_bits(f, 10);
        @(negedge clk);
        rst     = 1'b1;
        sen_drv = 1'b0;
        sd_drv  = f[2];
        sample();
        check("midrst_rw", RB2_RW, 1);
        check("midrst_a", RB2_A, 0);
        check("midrst_d", RB2_D, 0);
        check("midrst_done", S2_done, 0);
        @(negedge clk);
        rst     = 1'b0;
        sen_drv = 1'b1;
        idle(2);

        // Out-of-range address is rejected and not counted.
        send_frame(5'd20, 8'hEE, 1'b0);
        for (int a = 0; a < 17; a++) begin
            dd = 8'(a) ^ 8'h5A;
            send_frame(5'(a), dd, 1'b1);
        end
        idle(3);
        sample();
        check("done_after_17_valid", S2_done, 0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        sample();
        check("done_cleared_by_rst", S2_done, 0);

        // 18 back-to-back frames complete the bank.
        for (int a = 0; a < 18; a++) begin
            dd = 8'(a) ^ 8'h5A;
            send_frame(5'(a), dd, 1'b1);
        end
        sample();
        check("last_write_rw", RB2_RW, 0);
        check("done_in_last_write", S2_done, 0);
        @(negedge clk);
        sen_drv = 1'b1;
        sample();
        check("done_set", S2_done, 1);
        check("done_rw", RB2_RW, 1);

        // DONE ignores further traffic.
        send_frame(5'd2, 8'h11, 1'b0);
        idle(3);
        sample();
        check("done_held", S2_done, 1);
        check("done_rw_held", RB2_RW, 1);
        check("done_a_held", RB2_A, 17);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/s2_receiver.md
S2_RECEIVER -- requirements
Module: s2_receiver

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk      input   1  single clock; all state changes on rising edge
- rst      input   1  synchronous, active-high reset
- updown   input   1  direction select; 0 = S1->S2 transfer (this block receives), 1 = transfer disabled for this block
- sen      inout   1  serial frame enable, active low; never driven by this block (always high-Z)
- sd       inout   1  serial data, sampled while sen=0; never driven by this block (always high-Z)
- RB2_RW   output  1  register-bank-2 read/write; 1 = read, 0 = write
- RB2_A    output  5  register-bank-2 address
- RB2_D    output  8  register-bank-2 write data
- RB2_Q    input   8  register-bank-2 read data; unused in this release
- S2_done  output  1  all 18 words received and written
REQ-002 Reset SHALL be synchronous, active-high, on rst, sampled only at rising clk; single clock domain (clk).

Function
REQ-003 Frame format SHALL be 13 bits, one per cycle, sampled while sen=0: bits 0-4 = address (MSB first), bits 5-12 = data (MSB first).
REQ-004 FSM states SHALL be IDLE, SHIFT, WRITE, DONE.
REQ-005 IDLE: sen=0 and updown=0 -> capture sd as bit 0, bit counter=1, go SHIFT; else stay.
REQ-006 SHIFT: sen=0 -> shift sd into 13-bit register, increment counter; on capture of bit 12 go WRITE.
REQ-007 SHIFT: sen=1 before bit 12 captured (short frame) -> discard partial frame, counter=0, go IDLE, no write.
REQ-008 WRITE lasts exactly one cycle: RB2_RW=0, RB2_A=captured address, RB2_D=captured data; write latency = 1 cycle after bit 12 sampled.
REQ-009 Outside WRITE, RB2_RW SHALL be 1; RB2_A/RB2_D hold last values.
REQ-010 Captured address >17 SHALL be rejected: RB2_RW stays 1 during WRITE, word counter unchanged.
REQ-011 WRITE with sen=0 and updown=0 SHALL capture sd as bit 0 of next frame (back-to-back, zero gap), go SHIFT; else go IDLE.
REQ-012 5-bit word counter SHALL increment on each accepted write (address 0-17); a repeated address still counts.
REQ-013 When word counter reaches 18 after a write, go DONE; S2_done=1 from next cycle, held until rst.
REQ-014 DONE SHALL ignore sen/sd/updown; RB2_RW=1.
REQ-015 updown=1 in IDLE/SHIFT SHALL abort partial frame, go IDLE; a pending WRITE still completes.
REQ-016 sen and sd SHALL be high-Z in every state, including reset.
REQ-017 Bit counter SHALL be 4 bits, never exceeding 12; no wrap within a frame.

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE, bit counter=0, word counter=0, shift register=0, S2_done=0, RB2_RW=1, RB2_A=0, RB2_D=0, regardless of state.
REQ-019 Reset mid-frame or during WRITE SHALL suppress that write (RB2_RW=1 next cycle).

Verification
REQ-020 Single frame addr=5'd3, data=8'hA5, sen low 13 cycles -> one cycle after last bit, RB2_RW=0, RB2_A=3, RB2_D=8'hA5; then RB2_RW=1.
REQ-021 18 back-to-back frames, addresses 0..17, data=addr^8'h5A -> 18 single-cycle writes, correct pairs, S2_done=1 one cycle after 18th write, stays 1.
REQ-022 Short frame: sen high after 7 bits, then full frame addr=1, data=8'h0F -> only one write (addr 1, 8'h0F).
REQ-023 Frame with addr=5'd20 -> RB2_RW stays 1; word counter unchanged; S2_done stays 0 after 17 further valid frames.
REQ-024 updown=1 raised at bit 6 -> no write; after updown=0 a full frame writes normally.
REQ-025 rst=1 asserted at bit 10 of a frame -> all outputs at reset values next cycle, no write; sen/sd high-Z throughout.
